// File: rtl/pwm_ctrl_pkg.sv
// Shared types and the saturating duty-step function for the pwm fade controller.
package pwm_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StUpdate
  } state_t;

  // Next duty one rate step toward target; wide math so duty+rate never overflows.
  function automatic int unsigned sat_step(input int unsigned duty,
                                           input int unsigned target,
                                           input int unsigned rate);
    int unsigned sum;
    int unsigned diff;
    sum  = duty + rate;
    diff = duty - rate;
    if (rate == 0) begin
      return target;
    end else if (duty < target) begin
      return (sum > target) ? target : sum;
    end else if (duty > target) begin
      if (duty < rate) begin
        return target;
      end
      return (diff < target) ? target : diff;
    end
    return duty;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step prescaler and N-bit frame counter; step and frame_tick are registered pulses.
module pwm_prescaler #(
  parameter int unsigned N          = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_step,
  output logic                  o_frame_tick
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic [N-1:0]          r_fcnt;
  logic                  r_step;
  logic                  r_tick;
  logic                  w_hit;

  assign w_hit = (r_pcnt == i_prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_fcnt <= '0;
      r_step <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      // Also wraps silently when prescale dropped below the running count.
      r_pcnt <= (r_pcnt >= i_prescale) ? '0 : r_pcnt + 1'b1;
      r_step <= w_hit;
      r_tick <= w_hit && (r_fcnt == '1);
      if (w_hit) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign o_step       = r_step;
  assign o_frame_tick = r_tick;

endmodule

// File: rtl/pwm_fade_controller.sv
// Fade sequencer: once per PWM frame walks all channels, stepping each duty toward its target.
module pwm_fade_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PRESCALE_W-1:0]       i_prescale,
  input  logic                        i_cfg_valid,
  output logic                        o_cfg_ready,
  input  logic [$clog2(CHANNELS)-1:0] i_cfg_chan,
  input  logic [N-1:0]                i_cfg_target,
  input  logic [N-1:0]                i_cfg_rate,
  output logic                        o_step,
  output logic [CHANNELS*N-1:0]       o_duty,
  output logic [CHANNELS-1:0]         o_ena,
  output logic [CHANNELS-1:0]         o_done
);

  localparam int unsigned ChW = $clog2(CHANNELS);

  state_t             r_state;
  state_t             w_state_next;
  logic [ChW-1:0]     r_ch_idx;
  logic [N-1:0]       r_duty   [CHANNELS];
  logic [N-1:0]       r_target [CHANNELS];
  logic [N-1:0]       r_rate   [CHANNELS];
  logic [CHANNELS-1:0] r_done;

  logic               w_frame_tick;
  logic               w_cfg_fire;
  logic               w_cfg_hit;
  logic               w_last_ch;
  logic [N-1:0]       w_new_duty;
  logic               w_reach;

  pwm_prescaler #(
    .N         (N),
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .i_prescale  (i_prescale),
    .o_step      (o_step),
    .o_frame_tick(w_frame_tick)
  );

  always_comb begin
    w_state_next = r_state;
    o_cfg_ready  = (r_state == StIdle);
    w_cfg_fire   = i_cfg_valid && o_cfg_ready;
    // Writes to non-existent channels are acknowledged but dropped.
    w_cfg_hit    = w_cfg_fire && (32'(i_cfg_chan) < CHANNELS);
    w_last_ch    = (32'(r_ch_idx) == CHANNELS - 1);
    w_new_duty   = N'(sat_step(32'(r_duty[r_ch_idx]), 32'(r_target[r_ch_idx]),
                               32'(r_rate[r_ch_idx])));
    w_reach      = (r_state == StUpdate) && (w_new_duty != r_duty[r_ch_idx]) &&
                   (w_new_duty == r_target[r_ch_idx]);
    unique case (r_state)
      StIdle:   if (w_frame_tick) w_state_next = StUpdate;
      StUpdate: if (w_last_ch)    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ch_idx <= '0;
      r_done   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_duty[i]   <= '0;
        r_target[i] <= '0;
        r_rate[i]   <= '0;
      end
    end else begin
      r_state  <= w_state_next;
      r_ch_idx <= (r_state == StUpdate && !w_last_ch) ? r_ch_idx + 1'b1 : '0;
      if (w_cfg_hit) begin
        r_target[i_cfg_chan] <= i_cfg_target;
        r_rate[i_cfg_chan]   <= i_cfg_rate;
      end
      if (r_state == StUpdate) begin
        r_duty[r_ch_idx] <= w_new_duty;
      end
      r_done <= '0;
      if (w_reach) begin
        r_done[r_ch_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    o_duty = '0;
    o_ena  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      o_duty[i*N +: N] = r_duty[i];
      o_ena[i]         = (r_duty[i] != '0);
    end
  end

  assign o_done = r_done;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Scoreboard bench for pwm_fade_controller: expectations queued at stimulus, drained at sample points.
module tb_pwm_fade_controller;

  localparam int N  = 8;
  localparam int CH = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] prescale = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic [N-1:0]  cfg_target = '0;
  logic [N-1:0]  cfg_rate = '0;
  logic          step;
  logic [CH*N-1:0] duty;
  logic [CH-1:0] ena;
  logic [CH-1:0] done;

  pwm_fade_controller #(
    .N         (N),
    .CHANNELS  (CH),
    .PRESCALE_W(PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_prescale  (prescale),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_chan  (cfg_chan),
    .i_cfg_target(cfg_target),
    .i_cfg_rate  (cfg_rate),
    .o_step      (step),
    .o_duty      (duty),
    .o_ena       (ena),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int unsigned done_cnt [CH];
  int unsigned onehot_err;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) done_cnt[i] <= 0;
      onehot_err <= 0;
    end else begin
      for (int i = 0; i < CH; i++) done_cnt[i] <= done_cnt[i] + 32'(done[i]);
      if ($countones(done) > 1) onehot_err <= onehot_err + 1;
    end
  end

  typedef enum int {KDuty, KEna, KDoneCnt, KReady, KDoneRaw, KStepRaw, KOneHot, KVar} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          chan;
    int unsigned exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned var_val;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input kind_e k, input int ch, input int unsigned e);
    exp_t x;
    x.tag = tag; x.kind = k; x.chan = ch; x.exp = e;
    sb.push_back(x);
  endtask

  function automatic int unsigned actual(input kind_e k, input int ch);
    case (k)
      KDuty:    return 32'(duty[ch*N +: N]);
      KEna:     return 32'(ena[ch]);
      KDoneCnt: return done_cnt[ch];
      KReady:   return 32'(cfg_ready);
      KDoneRaw: return 32'(done);
      KStepRaw: return 32'(step);
      KOneHot:  return onehot_err;
      default:  return var_val;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, actual(e.kind, e.chan), e.exp);
    end
  endtask

  task automatic goto_cyc(input int unsigned k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int t, input int r);
    cfg_valid  = 1'b1;
    cfg_chan   = 2'(ch);
    cfg_target = N'(t);
    cfg_rate   = N'(r);
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  task automatic push_reset_state(input string pfx);
    for (int c = 0; c < CH; c++) begin
      push_exp({pfx, "_duty"}, KDuty, c, 0);
      push_exp({pfx, "_ena"}, KEna, c, 0);
    end
    push_exp({pfx, "_ready"}, KReady, 0, 1);
    push_exp({pfx, "_done"}, KDoneRaw, 0, 0);
    push_exp({pfx, "_step"}, KStepRaw, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    int unsigned low;

    // Reset state
    repeat (2) @(negedge clk);
    push_reset_state("rst");
    drain();
    #1 rst = 1'b0;

    // prescale = 0: a step every cycle
    goto_cyc(2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += 32'(step);
      @(negedge clk);
    end
    var_val = cnt;
    push_exp("steps_p0", KVar, 0, 20);
    drain();

    cfg_write(0, 200, 50);
    cfg_write(1, 200, 0);
    cfg_write(2, 255, 0);

    // frame 1
    goto_cyc(256 + 10);
    push_exp("f1_duty0", KDuty, 0, 50);
    push_exp("f1_duty1", KDuty, 1, 200);
    push_exp("f1_duty2", KDuty, 2, 255);
    push_exp("f1_ena2", KEna, 2, 1);
    push_exp("f1_done0", KDoneCnt, 0, 0);
    push_exp("f1_done1", KDoneCnt, 1, 1);
    drain();
    goto_cyc(256 + 20);
    cfg_write(1, 30, 100);
    cfg_write(2, 0, 0);

    // frame 2
    goto_cyc(2 * 256 + 10);
    push_exp("f2_duty0", KDuty, 0, 100);
    push_exp("f2_duty1", KDuty, 1, 100);
    push_exp("f2_duty2", KDuty, 2, 0);
    push_exp("f2_ena2", KEna, 2, 0);
    push_exp("f2_done1", KDoneCnt, 1, 1);
    drain();

    // frame 3: down-ramp clamps at target
    goto_cyc(3 * 256 + 10);
    push_exp("f3_duty0", KDuty, 0, 150);
    push_exp("f3_duty1", KDuty, 1, 30);
    push_exp("f3_done1", KDoneCnt, 1, 2);
    drain();

    // frame 4
    goto_cyc(4 * 256 + 10);
    push_exp("f4_duty0", KDuty, 0, 200);
    push_exp("f4_done0", KDoneCnt, 0, 1);
    drain();

    // frame 5: cfg_valid held through UPDATE
    goto_cyc(5 * 256 + 1);
    cfg_valid  = 1'b1;
    cfg_chan   = 2'd0;
    cfg_target = N'(100);
    cfg_rate   = '0;
    low = 0;
    for (int i = 0; i < 20 && !cfg_ready; i++) begin
      low++;
      @(negedge clk);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    var_val = low;
    push_exp("rdy_low_cycles", KVar, 0, 4);
    drain();
    goto_cyc(5 * 256 + 10);
    push_exp("f5_duty0", KDuty, 0, 200);
    push_exp("f5_duty1", KDuty, 1, 30);
    push_exp("f5_done0", KDoneCnt, 0, 1);
    push_exp("f5_done1", KDoneCnt, 1, 2);
    drain();

    // frame 6: write in the frame_tick cycle
    goto_cyc(6 * 256);
    cfg_write(1, 77, 0);
    goto_cyc(6 * 256 + 10);
    push_exp("f6_duty0", KDuty, 0, 100);
    push_exp("f6_duty1", KDuty, 1, 77);
    push_exp("f6_done0", KDoneCnt, 0, 2);
    push_exp("f6_done1", KDoneCnt, 1, 3);
    drain();
    goto_cyc(6 * 256 + 20);
    cfg_write(0, 40, 0);
    cfg_write(1, 41, 0);
    cfg_write(2, 9, 0);
    cfg_write(3, 5, 0);

    // frame 7: reset while ch_idx == 2
    goto_cyc(7 * 256 + 3);
    push_exp("f7_duty0", KDuty, 0, 40);
    push_exp("f7_duty1", KDuty, 1, 41);
    push_exp("f7_duty2_pending", KDuty, 2, 0);
    push_exp("f7_ready", KReady, 0, 0);
    push_exp("onehot", KOneHot, 0, 0);
    drain();
    #1 rst = 1'b1;
    #1;
    push_reset_state("midrst");
    drain();
    @(negedge clk);
    #1 rst = 1'b0;

    goto_cyc(10);
    cfg_write(3, 10, 0);
    goto_cyc(256 + 10);
    push_exp("post_duty3", KDuty, 3, 10);
    push_exp("post_ena3", KEna, 3, 1);
    push_exp("post_duty2", KDuty, 2, 0);
    push_exp("post_ena2", KEna, 2, 0);
    push_exp("post_done3", KDoneCnt, 3, 1);
    drain();

    // prescale = 3: one step every 4th cycle
    prescale = PW'(3);
    repeat (8) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cnt += 32'(step);
      @(negedge clk);
    end
    var_val = cnt;
    push_exp("steps_p3", KVar, 0, 10);
    push_exp("onehot_end", KOneHot, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pwm_fade_controller.md
Name: pwm_fade_controller

Overview:
Sequencer that drives a bank of CHANNELS pwm instances. It produces the shared step enable from a programmable prescaler, counts PWM frames, and once per frame ramps each channel's duty toward a programmed target at a programmed rate. Configuration arrives over a valid/ready write port; the block sits between the control/register logic and the pwm bank.

Parameters:
N, 8, duty width; must match the pwm instances; frame = 2^N steps
CHANNELS, 4, number of PWM channels controlled (>=2)
PRESCALE_W, 16, width of the prescale input

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
prescale  in  PRESCALE_W  step period minus 1; sampled live
cfg_valid  in  1  config write request
cfg_ready  out  1  high when a write can be accepted
cfg_chan  in  $clog2(CHANNELS)  channel index for the write
cfg_target  in  N  target duty
cfg_rate  in  N  duty change per frame; 0 = jump to target
step  out  1  one-cycle pulse; fan out to the step input of every pwm
duty  out  CHANNELS*N  current duty; channel i at bits [i*N +: N]
ena  out  CHANNELS  ena[i] = (duty_i != 0), combinational from registers
done  out  CHANNELS  one-cycle pulse when a channel's duty reaches its target

Behaviour:
- Reset (asynchronous, immediate): duty, target and rate all 0; prescaler and frame counters 0; step=0; done=0; state IDLE; cfg_ready=1; ena=0.
- Prescaler:
  - Counter pcnt; step=1 in the cycle pcnt==prescale, and pcnt returns to 0; otherwise pcnt+1.
  - If pcnt>prescale after a prescale change, pcnt wraps to 0 with no step.
  - prescale=0 gives step every cycle.
- Frame counter: N bits, increments on each step. A step with fcnt==2^N-1 wraps it to 0 and raises frame_tick for that cycle.
- FSM states are IDLE and UPDATE.
  - IDLE: cfg_ready=1. frame_tick moves the FSM to UPDATE on the next edge, with ch_idx=0.
  - UPDATE: cfg_ready=0. Processes one channel per cycle, ch_idx 0..CHANNELS-1. Returns to IDLE after the last channel, so UPDATE lasts exactly CHANNELS cycles.
  - The prescaler and frame counter keep running in every state. A frame_tick during UPDATE is not possible for CHANNELS < 2^N; it is not queued.
- Config write:
  - Accepted on the edge where cfg_valid & cfg_ready.
  - Loads target[cfg_chan] and rate[cfg_chan]. Does not modify duty.
  - A write in the same cycle as frame_tick takes effect, and the following UPDATE uses the new values.
  - cfg_chan >= CHANNELS: the write is accepted and discarded.
- Per-channel update (ch_idx = c), duty computed in N+1 bits:
  - rate==0: duty <= target.
  - duty < target: duty <= min(duty+rate, target).
  - duty > target: duty <= (duty < rate) ? target : max(duty-rate, target).
  - duty==target: no change, no done pulse.
  - done[c] pulses for one cycle, on the cycle after the update in which duty changed to equal target. At most one bit of done is high at a time.
- Latency: duty changes within CHANNELS+1 cycles after frame_tick; channel c updates on cycle c+1 after frame_tick.
- Reset asserted mid-UPDATE: the FSM returns to IDLE immediately and all state clears. There is no partial-update residue.

Decomposition:
- Package pwm_ctrl_pkg:
  - enum state_t {IDLE, UPDATE}
  - function sat_step(duty, target, rate) returning next duty, shared with the bench model
- Sub-module pwm_prescaler(clk, rst, prescale, step, frame_tick), parameterised N and PRESCALE_W; contains pcnt and fcnt.
- Top module holds the FSM, ch_idx, the register arrays and the done generation.

Test Plan:
- Reset, then prescale=0 -> step every cycle, frame_tick every 256 cycles; prescale=3 -> step every 4th cycle; after reset all duty=0, ena=0, cfg_ready=1.
- ch0 target=200, rate=50 -> duty0 is 50,100,150,200 after frames 1-4; done[0] pulses once after frame 4; later frames cause no change and no pulse.
- ch1 ramped to 200, then target=30, rate=100 -> duty1 is 100, then 30 (clamped, no underflow); done[1] pulses once.
- ch2 target=255, rate=0 -> duty2=255 after the first frame and ena[2]=1; then target=0, rate=0 -> duty2=0 and ena[2]=0 next frame.
- cfg_valid held from the cycle after frame_tick -> cfg_ready=0 for exactly 4 cycles; write accepted on the first IDLE cycle; the same-cycle frame_tick/write case applies the new target in that frame.
- Assert rst for 1 cycle during UPDATE at ch_idx=2 -> all outputs 0 immediately; IDLE; ch3 not updated; normal operation resumes after rst deasserts.
